// File: rtl/approx_div_pkg.sv
// ----------------------------------------------------------------------------
// approx_div_pkg : shared FSM encodings and width helper for approx_seq_divider
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package approx_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < value) w++;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/param_full_subtractor.sv
// ----------------------------------------------------------------------------
// param_full_subtractor : one-bit subtractor cell, exact or approximate diff
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module param_full_subtractor #(
  parameter int APPROX = 0
) (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign bout = (~a & b) | (~a & bin) | (b & bin);

  generate
    if (APPROX != 0) begin : g_approx
      assign diff = bout;
    end else begin : g_exact
      assign diff = a ^ b ^ bin;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/approx_seq_divider.sv
// ----------------------------------------------------------------------------
// approx_seq_divider : iterative restoring divider, one quotient bit per clock
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module approx_seq_divider
  import approx_div_pkg::*;
#(
  parameter int N           = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int            CW     = clog2(N);
  localparam logic [CW-1:0] c_last = CW'(N - 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_d;
  logic          r_dbz;
  logic          w_accept;
  logic          w_fin_exit;
  logic [N:0]    w_a;
  logic [N:0]    w_b;
  logic [N:0]    w_diff;
  logic [N+1:0]  w_borrow;
  logic [1:0]    w_unused;

  assign w_a         = {r_rem, r_q[N-1]};
  assign w_b         = {1'b0, r_d};
  assign w_borrow[0] = 1'b0;
  // Restoring keeps R below the divisor, so bit N never carries information.
  assign w_unused    = {w_diff[N], w_a[N]};

  generate
    for (genvar i = 0; i <= N; i++) begin : g_cell
      param_full_subtractor #(
        .APPROX ((i < APPROX_BITS) ? 1 : 0)
      ) u_cell (
        .a    (w_a[i]),
        .b    (w_b[i]),
        .bin  (w_borrow[i]),
        .diff (w_diff[i]),
        .bout (w_borrow[i+1])
      );
    end
  endgenerate

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_fin_exit = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = (divisor == '0) ? FIN : CALC;
        end
      end
      CALC: begin
        if (r_cnt == c_last) w_next = FIN;
      end
      FIN: begin
        // Divide-by-zero dwells one extra cycle in FIN to match the 2-cycle latency.
        if (!r_dbz || (r_cnt != '0)) begin
          w_next     = IDLE;
          w_fin_exit = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_dbz       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= w_fin_exit;
      if (w_accept) begin
        r_cnt <= '0;
        r_rem <= '0;
        r_q   <= dividend;
        r_d   <= divisor;
        r_dbz <= (divisor == '0);
        busy  <= 1'b1;
      end else if (r_state == CALC) begin
        r_q   <= {r_q[N-2:0], ~w_borrow[N+1]};
        r_rem <= w_borrow[N+1] ? w_a[N-1:0] : w_diff[N-1:0];
        if (r_cnt != c_last) r_cnt <= r_cnt + CW'(1);
      end else if ((r_state == FIN) && !w_fin_exit) begin
        r_cnt <= CW'(1);
      end
      if (w_fin_exit) begin
        busy        <= 1'b0;
        quotient    <= r_dbz ? '1 : r_q;
        remainder   <= r_dbz ? r_q : r_rem;
        div_by_zero <= r_dbz;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_approx_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_approx_seq_divider : directed + random checks of exact and approximate divider
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_approx_seq_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start0, start2;
  logic [N-1:0] dvd0, dvs0, dvd2, dvs2;
  logic         busy0, done0, dbz0, busy2, done2, dbz2;
  logic [N-1:0] q0, r0, q2, r2;

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  logic         s_busy, s_done, s_dbz;
  logic [N-1:0] s_q, s_r;

  assign s_busy = (sel == 2) ? busy2 : busy0;
  assign s_done = (sel == 2) ? done2 : done0;
  assign s_dbz  = (sel == 2) ? dbz2  : dbz0;
  assign s_q    = (sel == 2) ? q2    : q0;
  assign s_r    = (sel == 2) ? r2    : r0;

  always #5 clk = ~clk;

  approx_seq_divider #(.N(N), .APPROX_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .dividend(dvd0), .divisor(dvs0),
    .busy(busy0), .done(done0), .quotient(q0), .remainder(r0), .div_by_zero(dbz0)
  );

  approx_seq_divider #(.N(N), .APPROX_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .dividend(dvd2), .divisor(dvs2),
    .busy(busy2), .done(done2), .quotient(q2), .remainder(r2), .div_by_zero(dbz2)
  );

  // Reference: shift-and-subtract with approximate low difference bits taken as
  // the borrow out of each low cell, i.e. (R mod 2^(i+1)) < (D mod 2^(i+1)).
  function automatic void ref_div(input int a, input int d, input int ab,
                                  output int q, output int r);
    int rr, qq, t;
    if (d == 0) begin
      q = 255;
      r = a;
      return;
    end
    rr = 0;
    qq = a;
    for (int it = 0; it < N; it++) begin
      rr = ((rr & 255) << 1) | ((qq >> 7) & 1);
      qq = (qq << 1) & 255;
      if (rr >= d) begin
        t = rr - d;
        for (int i = 0; i < ab; i++) begin
          if ((rr % (1 << (i + 1))) < (d % (1 << (i + 1)))) t = t | (1 << i);
          else                                              t = t & ~(1 << i);
        end
        rr = t;
        qq = qq | 1;
      end
    end
    q = qq;
    r = rr & 255;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int s, input logic st, input logic [N-1:0] a, input logic [N-1:0] d);
    if (s == 2) begin
      start2 = st; dvd2 = a; dvs2 = d;
    end else begin
      start0 = st; dvd0 = a; dvs0 = d;
    end
  endtask

  task automatic wait_done(inout int lat);
    while (!s_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int a, input int d, input int ab);
    int q_e, r_e;
    ref_div(a, d, ab, q_e, r_e);
    check({tag, " latency"}, lat, (d == 0) ? 2 : N + 1);
    check({tag, " quotient"}, s_q, q_e);
    check({tag, " remainder"}, s_r, r_e);
    check({tag, " dbz"}, s_dbz, (d == 0) ? 1 : 0);
    check({tag, " busy_at_done"}, s_busy, 0);
  endtask

  task automatic op(input int s, input logic [N-1:0] a, input logic [N-1:0] d, input string tag);
    int lat;
    sel = s;
    @(negedge clk); drive(s, 1'b1, a, d);
    @(posedge clk); #1; drive(s, 1'b0, N'($urandom), N'($urandom));
    check({tag, " busy"}, s_busy, 1);
    lat = 0;
    wait_done(lat);
    check_result(tag, lat, a, d, (s == 2) ? 2 : 0);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, s_done, 0);
  endtask

  initial begin
    int lat, seen;
    rst = 1'b1;
    drive(0, 1'b0, '0, '0);
    drive(2, 1'b0, '0, '0);
    #12;
    check("reset busy", busy0, 0);
    check("reset done", done0, 0);
    check("reset quotient", q2, 0);
    check("reset remainder", r2, 0);
    check("reset dbz", dbz0, 0);
    @(negedge clk); rst = 1'b0;

    op(0, 8'd100, 8'd7,  "exact_100_7");
    op(0, 8'd255, 8'd1,  "exact_255_1");
    op(0, 8'd5,   8'd9,  "exact_5_9");
    op(0, 8'h3C,  8'd0,  "dbz_exact");
    op(2, 8'h3C,  8'd0,  "dbz_approx");
    op(2, 8'd16,  8'd4,  "approx_16_4");
    check("approx_16_4 spec quotient", q2, 4);
    check("approx_16_4 spec remainder", r2, 0);
    op(0, 8'd255, 8'd255, "exact_255_255");

    // Reset four cycles into CALC: no done, all outputs cleared.
    sel = 0;
    @(negedge clk); drive(0, 1'b1, 8'd200, 8'd3);
    @(posedge clk); #1; drive(0, 1'b0, 8'd0, 8'd0);
    repeat (4) @(posedge clk);
    #1; rst = 1'b1; #1;
    check("midreset busy", busy0, 0);
    check("midreset quotient", q0, 0);
    check("midreset remainder", r0, 0);
    check("midreset dbz", dbz0, 0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done0) seen++;
    end
    check("midreset no_done", seen, 0);
    op(0, 8'd200, 8'd3, "after_reset");

    // start pulsed mid-CALC is ignored.
    sel = 0;
    @(negedge clk); drive(0, 1'b1, 8'd77, 8'd5);
    @(posedge clk); #1; drive(0, 1'b0, 8'd0, 8'd0);
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    drive(0, 1'b1, 8'd200, 8'd13);
    @(posedge clk); #1; lat++;
    drive(0, 1'b0, 8'd0, 8'd0);
    wait_done(lat);
    check_result("ignored_start", lat, 77, 5, 0);
    @(posedge clk); #1;
    check("ignored_start busy_after", busy0, 0);

    // start held high: back-to-back operations, new operands captured.
    sel = 2;
    @(negedge clk); drive(2, 1'b1, 8'd201, 8'd6);
    @(posedge clk); #1; drive(2, 1'b1, 8'd143, 8'd11);
    lat = 0;
    wait_done(lat);
    check_result("b2b first", lat, 201, 6, 2);
    @(posedge clk); #1; drive(2, 1'b0, 8'd0, 8'd0);
    check("b2b reaccept busy", busy2, 1);
    check("b2b reaccept done", done2, 0);
    lat = 0;
    seen = 0;
    wait_done(lat);
    check_result("b2b second", lat, 143, 11, 2);
    repeat (4) begin
      @(posedge clk); #1;
      if (done2) seen++;
    end
    check("b2b single_done", seen, 0);

    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] a, d;
      a = N'($urandom);
      d = (i % 9 == 4) ? 8'd0 : ((i % 3 == 0) ? N'($urandom_range(1, 15)) : N'($urandom_range(1, 255)));
      op((i % 2 == 0) ? 2 : 0, a, d, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
